// File: rtl/array_keyboard_pkg.sv
// Shared constants, row-select encoding and key-index helper for the 4x4 matrix keyboard scanner.
package array_keyboard_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    // One-hot-low row drive patterns, row 0 first.
    localparam logic [NUM_ROWS-1:0] ROW_DRIVE_0 = 4'b1110;
    localparam logic [NUM_ROWS-1:0] ROW_DRIVE_1 = 4'b1101;
    localparam logic [NUM_ROWS-1:0] ROW_DRIVE_2 = 4'b1011;
    localparam logic [NUM_ROWS-1:0] ROW_DRIVE_3 = 4'b0111;

    typedef enum logic [1:0] {
        ROW_0 = 2'd0,
        ROW_1 = 2'd1,
        ROW_2 = 2'd2,
        ROW_3 = 2'd3
    } row_sel_t;

    // Key k = 4*row + col.
    function automatic logic [3:0] key_index(input logic [1:0] row_idx, input logic [1:0] col_idx);
        return 4'(NUM_COLS * int'(row_idx) + int'(col_idx));
    endfunction

endpackage

// File: rtl/array_keyboard_scan_div.sv
// Dwell counter: counts 0..CNT_200HZ-1 and flags the last cycle of each dwell as the scan tick.
module array_keyboard_scan_div #(
    parameter int CNT_200HZ = 60000,
    parameter int WIDTH     = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(CNT_200HZ - 1);

    logic [WIDTH-1:0] count;

    // Free-running dwell counter, wraps after the tick cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/array_keyboard.sv
// 4x4 matrix keyboard scanner: steps one low row per dwell, samples columns on the tick,
// keeps active-low key state and a one-clock press strobe per key.
// Optional macro ARRAY_KEYBOARD_DEBOUNCE_EN: require two agreeing samples one scan apart.
module array_keyboard
    import array_keyboard_pkg::*;
#(
    parameter int CNT_200HZ = 60000,
    parameter int WIDTH     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] key_out,
    output logic [15:0] key_pulse
);

    logic                tick;
    row_sel_t            row_sel;
    row_sel_t            row_sel_next;
    logic                sample_valid;
    logic [1:0]          sample_row;
    logic [NUM_COLS-1:0] sample_col;
    logic [NUM_KEYS-1:0] key_next;
`ifdef ARRAY_KEYBOARD_DEBOUNCE_EN
    logic [NUM_KEYS-1:0] history;
    logic [NUM_KEYS-1:0] history_next;
`endif

    array_keyboard_scan_div #(
        .CNT_200HZ (CNT_200HZ),
        .WIDTH     (WIDTH)
    ) u_scan_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Row-select state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_sel <= ROW_0;
        end else begin
            row_sel <= row_sel_next;
        end
    end

    // Row advance on tick and one-hot-low row drive decode.
    always_comb begin
        row_sel_next = row_sel;
        row          = ROW_DRIVE_0;
        unique case (row_sel)
            ROW_0: begin
                row = ROW_DRIVE_0;
                if (tick) row_sel_next = ROW_1;
            end
            ROW_1: begin
                row = ROW_DRIVE_1;
                if (tick) row_sel_next = ROW_2;
            end
            ROW_2: begin
                row = ROW_DRIVE_2;
                if (tick) row_sel_next = ROW_3;
            end
            ROW_3: begin
                row = ROW_DRIVE_3;
                if (tick) row_sel_next = ROW_0;
            end
        endcase
    end

    // Capture the settled columns of the driven row on the tick, before the row moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_valid <= 1'b0;
            sample_row   <= '0;
            sample_col   <= '1;
        end else begin
            sample_valid <= tick;
            if (tick) begin
                sample_row <= row_sel;
                sample_col <= col;
            end
        end
    end

    // Merge the captured row into the key state; other rows hold.
    always_comb begin
        key_next = key_out;
`ifdef ARRAY_KEYBOARD_DEBOUNCE_EN
        history_next = history;
`endif
        if (sample_valid) begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
`ifdef ARRAY_KEYBOARD_DEBOUNCE_EN
                if (sample_col[2'(c)] == history[key_index(sample_row, 2'(c))] &&
                    sample_col[2'(c)] != key_out[key_index(sample_row, 2'(c))]) begin
                    key_next[key_index(sample_row, 2'(c))] = sample_col[2'(c)];
                end
                history_next[key_index(sample_row, 2'(c))] = sample_col[2'(c)];
`else
                key_next[key_index(sample_row, 2'(c))] = sample_col[2'(c)];
`endif
            end
        end
    end

    // Key state, press strobe on 1->0 transitions, and sample history.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_out   <= '1;
            key_pulse <= '0;
`ifdef ARRAY_KEYBOARD_DEBOUNCE_EN
            history   <= '1;
`endif
        end else begin
            key_out   <= key_next;
            key_pulse <= key_out & ~key_next;
`ifdef ARRAY_KEYBOARD_DEBOUNCE_EN
            history   <= history_next;
`endif
        end
    end

endmodule

// File: tb/tb_array_keyboard.sv
// Directed bench for array_keyboard with a short dwell (10 clocks, 40-clock scan).
// Edge numbering in comments counts rising edges after reset release.
module tb_array_keyboard;

`ifdef ARRAY_KEYBOARD_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam int CNT = 10;
    localparam int WID = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key_out;
    logic [15:0] key_pulse;

    logic [3:0]  col_drive  = 4'b1111;
    logic        use_matrix = 1'b0;
    logic [15:0] pressed    = 16'h0000;
    logic [3:0]  matrix_col;

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt [16] = '{default: 0};
    int base      [16] = '{default: 0};

    always #42 clk = ~clk;

    array_keyboard #(
        .CNT_200HZ (CNT),
        .WIDTH     (WID)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key_out   (key_out),
        .key_pulse (key_pulse)
    );

    // Physical matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        matrix_col = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row[r] && pressed[r*4+c]) matrix_col[c] = 1'b0;
        col = use_matrix ? matrix_col : col_drive;
    end

    // Count pulse cycles per key just after each rising edge.
    always @(posedge clk) begin
        #1;
        for (int b = 0; b < 16; b++)
            if (key_pulse[b]) pulse_cnt[b]++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        for (int b = 0; b < 16; b++) base[b] = pulse_cnt[b];
    endtask

    function automatic int pulses_since(input int b);
        return pulse_cnt[b] - base[b];
    endfunction

    function automatic int total_since();
        int s = 0;
        for (int b = 0; b < 16; b++) s += pulse_cnt[b] - base[b];
        return s;
    endfunction

    function automatic int single_pulse_keys();
        int s = 0;
        for (int b = 0; b < 16; b++) if (pulse_cnt[b] - base[b] == 1) s++;
        return s;
    endfunction

    initial begin
        // Reset held: outputs pinned every cycle.
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("rst_row", 32'(row), 32'h0000_000E);
            check("rst_key", 32'(key_out), 32'h0000_FFFF);
            check("rst_pulse", 32'(key_pulse), 32'h0);
        end
        rst = 1'b0;
        mark();

        // Idle scan: row steps at edges 10, 20, 30, 40.
        step(9);  check("idle_row0", 32'(row), 32'hE);
        step(1);  check("idle_row1", 32'(row), 32'hD);
        step(10); check("idle_row2", 32'(row), 32'hB);
        step(10); check("idle_row3", 32'(row), 32'h7);
        step(10); check("idle_wrap", 32'(row), 32'hE);
        check("idle_key", 32'(key_out), 32'hFFFF);
        check("idle_pulses", 32'(total_since()), 32'd0);

        // Column 0 held (edge 40 = start of row 0 dwell).
        mark();
        col_drive = 4'b1110;
        step(10); check("col0_before", 32'(key_out), 32'hFFFF);
        step(1);  check("col0_first", 32'(key_out), DEB ? 32'hFFFF : 32'hFFFE);
                  check("col0_pulse", 32'(key_pulse), DEB ? 32'h0 : 32'h1);
        step(1);  check("col0_pulse_end", 32'(key_pulse), 32'h0);
        step(108);
        check("col0_key", 32'(key_out), 32'hEEEE);
        check("col0_p0", 32'(pulses_since(0)), 32'd1);
        check("col0_p4", 32'(pulses_since(4)), 32'd1);
        check("col0_p8", 32'(pulses_since(8)), 32'd1);
        check("col0_p12", 32'(pulses_since(12)), 32'd1);
        check("col0_total", 32'(total_since()), 32'd4);

        // Release: no pulses.
        mark();
        col_drive = 4'b1111;
        step(120);
        check("rel_key", 32'(key_out), 32'hFFFF);
        check("rel_pulses", 32'(total_since()), 32'd0);

        // All keys pressed.
        mark();
        col_drive = 4'b0000;
        step(120);
        check("all_key", 32'(key_out), 32'h0000);
        check("all_total", 32'(total_since()), 32'd16);
        check("all_single", 32'(single_pulse_keys()), 32'd16);
        mark();
        col_drive = 4'b1111;
        step(120);
        check("all_rel_key", 32'(key_out), 32'hFFFF);
        check("all_rel_pulses", 32'(total_since()), 32'd0);

        // Glitch on columns 0,1 for 8 clocks spanning the row-0 sample at edge 530.
        step(5);
        mark();
        col_drive = 4'b1100;
        step(8);
        col_drive = 4'b1111;
        check("glitch_key", 32'(key_out), DEB ? 32'hFFFF : 32'hFFFC);
        step(47);
        check("glitch_after", 32'(key_out), 32'hFFFF);
        check("glitch_pulses", 32'(total_since()), DEB ? 32'd0 : 32'd2);

        // Key 9 (row 2, col 1) held via the matrix, then reset mid row 2.
        mark();
        pressed    = 16'h0200;
        use_matrix = 1'b1;
        step(200);
        check("hold_row2", 32'(row), 32'hB);
        check("hold_key", 32'(key_out), 32'hFDFF);
        check("hold_p9", 32'(pulses_since(9)), 32'd1);
        check("hold_total", 32'(total_since()), 32'd1);
        step(3);
        rst = 1'b1;
        mark();
        step(1);
        check("mrst_row", 32'(row), 32'hE);
        check("mrst_key", 32'(key_out), 32'hFFFF);
        check("mrst_pulse", 32'(key_pulse), 32'h0);
        step(2);
        rst = 1'b0;
        step(120);
        check("rereg_key", 32'(key_out), 32'hFDFF);
        check("rereg_p9", 32'(pulses_since(9)), 32'd1);
        check("rereg_total", 32'(total_since()), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
